// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Next channel index with wrap back to 0 after nch-1.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned nch);
    return ((idx + 32'd1) >= nch) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... with wrap,
// so the channel at ptr itself has the lowest priority.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [SELW-1:0] gnt_o,
  output logic            gnt_valid_o
);

  always_comb begin
    int unsigned idx;
    logic [SELW-1:0] idx_sel;
    logic found;
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    found       = 1'b0;
    idx         = 32'(ptr_i);
    idx_sel     = ptr_i;
    for (int k = 0; k < NCH; k++) begin
      idx     = next_idx(idx, 32'(NCH));
      idx_sel = SELW'(idx);
      if (!found && req_i[idx_sel]) begin
        found = 1'b1;
        gnt_o = idx_sel;
      end else begin
        found = found;
      end
    end
    gnt_valid_o = found;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with fixed-select or round-robin grant
// and valid/ready handshakes on every input and on the single output.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NCH*WIDTH-1:0]   in_data_i,
  input  logic [NCH-1:0]         in_valid_i,
  output logic [NCH-1:0]         in_ready_o,
  input  logic [SELW-1:0]        sel_i,
  input  logic                   mode_i,
  output logic [WIDTH-1:0]       out_data_o,
  output logic [SELW-1:0]        out_ch_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load_s;
  logic             fixed_hit_s;
  logic [SELW-1:0]  rr_gnt_s;
  logic             rr_gnt_valid_s;
  logic [SELW-1:0]  gnt_s;
  logic             gnt_valid_s;
  logic [WIDTH-1:0] gnt_data_s;

  assign load_s = ~out_valid_q | out_ready_i;

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req_i       (in_valid_i),
    .ptr_i       (ptr_q),
    .gnt_o       (rr_gnt_s),
    .gnt_valid_o (rr_gnt_valid_s)
  );

  // An out-of-range sel matches no channel, so it can never grant.
  always_comb begin
    fixed_hit_s = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (sel_i == SELW'(i)) begin
        fixed_hit_s = in_valid_i[i];
      end else begin
        fixed_hit_s = fixed_hit_s;
      end
    end
  end

  always_comb begin
    gnt_s       = '0;
    gnt_valid_s = 1'b0;
    case (mode_i)
      MODE_RR: begin
        gnt_s       = rr_gnt_s;
        gnt_valid_s = rr_gnt_valid_s;
      end
      MODE_FIXED: begin
        gnt_s       = sel_i;
        gnt_valid_s = fixed_hit_s;
      end
      default: begin
        gnt_s       = '0;
        gnt_valid_s = 1'b0;
      end
    endcase
  end

  always_comb begin
    in_ready_o = '0;
    gnt_data_s = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_s == SELW'(i)) begin
        in_ready_o[i] = ~rst_i & load_s & gnt_valid_s;
        gnt_data_s    = in_data_i[i*WIDTH +: WIDTH];
      end else begin
        in_ready_o[i] = 1'b0;
      end
    end
  end

  // Output register only moves when it is empty or being drained.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load_s) begin
      if (gnt_valid_s) begin
        out_data_d  = gnt_data_s;
        out_ch_d    = gnt_s;
        out_valid_d = 1'b1;
        if (mode_i == MODE_RR) begin
          ptr_d = gnt_s;
        end else begin
          ptr_d = ptr_q;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SELW'(NCH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (WIDTH=2, NCH=4); channel i carries data 3-i.
module tb_stream_mux_rr;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [1:0] sel;
  logic       mode;
  logic [1:0] out_data;
  logic [1:0] out_ch;
  logic       out_valid;
  logic       out_ready;

  int errors = 0;
  int checks = 0;

  stream_mux_rr #(.WIDTH(2), .NCH(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .sel_i       (sel),
    .mode_i      (mode),
    .out_data_o  (out_data),
    .out_ch_o    (out_ch),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'hF; mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready0 got=%b exp=0000", in_ready); end
    step();
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready1 got=%b exp=0000", in_ready); end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 2'd0 || out_ch !== 2'd0)
      begin errors++; $display("FAIL reset_out got v=%b d=%0d c=%0d exp v=0 d=0 c=0", out_valid, out_data, out_ch); end
    rst = 1'b0; in_valid = 4'h0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_fixed();
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready got=%b exp=0100", in_ready); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 2'd1 || out_ch !== 2'd2)
      begin errors++; $display("FAIL fixed_out got v=%b d=%0d c=%0d exp v=1 d=1 c=2", out_valid, out_data, out_ch); end
    in_valid = 4'b1011;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL fixed_noreq_ready got=%b exp=0000", in_ready); end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 2'd1 || out_ch !== 2'd2)
      begin errors++; $display("FAIL fixed_bubble got v=%b d=%0d c=%0d exp v=0 d=1 c=2", out_valid, out_data, out_ch); end
    in_valid = 4'h0;
  endtask

  task automatic test_rr_all();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'(i % 4) || out_data !== 2'(3 - (i % 4)))
        begin errors++; $display("FAIL rr_seq[%0d] got v=%b c=%0d d=%0d exp v=1 c=%0d d=%0d", i, out_valid, out_ch, out_data, i % 4, 3 - (i % 4)); end
    end
    in_valid = 4'h0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [1:0] exp_ch [$];
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 2'd3)
      begin errors++; $display("FAIL bp_first got v=%b c=%0d d=%0d exp v=1 c=0 d=3", out_valid, out_ch, out_data); end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, in_ready); end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 2'd3)
        begin errors++; $display("FAIL bp_hold[%0d] got v=%b c=%0d d=%0d exp v=1 c=0 d=3", i, out_valid, out_ch, out_data); end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got=%b exp=0010", in_ready); end
    exp_ch.push_back(2'd1);
    exp_ch.push_back(2'd2);
    while (exp_ch.size() > 0) begin
      logic [1:0] e;
      e = exp_ch.pop_front();
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== e || out_data !== 2'd3 - e)
        begin errors++; $display("FAIL bp_after got v=%b c=%0d d=%0d exp v=1 c=%0d", out_valid, out_ch, out_data, e); end
    end
    in_valid = 4'h0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_sparse();
    logic [1:0] exp_seq [7];
    logic [3:0] vld_seq [7];
    exp_seq = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd1, 2'd1};
    vld_seq = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b0010, 4'b0010, 4'b0010};
    mode = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = vld_seq[i];
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== exp_seq[i] || out_data !== 2'd3 - exp_seq[i])
        begin errors++; $display("FAIL sparse[%0d] got v=%b c=%0d d=%0d exp v=1 c=%0d", i, out_valid, out_ch, out_data, exp_seq[i]); end
    end
  endtask

  task automatic test_mode_switch();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    step();
    checks++;
    if (out_ch !== 2'd2 || out_data !== 2'd1) begin errors++; $display("FAIL ms_rr got c=%0d d=%0d exp c=2 d=1", out_ch, out_data); end
    out_ready = 1'b0; mode = 1'b0; sel = 2'd0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 2'd1 || in_ready !== 4'b0000)
        begin errors++; $display("FAIL ms_hold[%0d] got v=%b c=%0d d=%0d r=%b exp v=1 c=2 d=1 r=0000", i, out_valid, out_ch, out_data, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("FAIL ms_fixed_ready got=%b exp=0001", in_ready); end
    step();
    checks++;
    if (out_ch !== 2'd0 || out_data !== 2'd3) begin errors++; $display("FAIL ms_fixed got c=%0d d=%0d exp c=0 d=3", out_ch, out_data); end
    mode = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin errors++; $display("FAIL ms_resume_ready got=%b exp=1000", in_ready); end
    step();
    checks++;
    if (out_ch !== 2'd3 || out_data !== 2'd0) begin errors++; $display("FAIL ms_resume got c=%0d d=%0d exp c=3 d=0", out_ch, out_data); end
    rst = 1'b1; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL ms_rst_ready got=%b exp=0000", in_ready); end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_data !== 2'd0)
      begin errors++; $display("FAIL ms_rst_out got v=%b c=%0d d=%0d exp v=0 c=0 d=0", out_valid, out_ch, out_data); end
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'(i))
        begin errors++; $display("FAIL ms_restart[%0d] got v=%b c=%0d exp v=1 c=%0d", i, out_valid, out_ch, i); end
    end
    in_valid = 4'h0;
  endtask

  initial begin
    in_data = 8'h1B;
    rst = 1'b1; in_valid = 4'h0; sel = 2'd0; mode = 1'b0; out_ready = 1'b0;
    test_reset();
    test_fixed();
    test_rr_all();
    test_backpressure();
    test_sparse();
    test_mode_switch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit registered stream multiplexer. It generalises the fixed 2-bit 4:1 select mux to any width and channel count, and adds valid/ready flow control on every input and on the output. It has two selection modes: externally selected channel, or fair round-robin among valid channels. It sits between several producer streams and a single consumer, with one output register stage.

## Interface
- WIDTH, default 2: data bits per channel.
- NCH, default 4: number of input channels, 2..16.
- SELW, default $clog2(NCH): width of channel index.
- Clk  input  1  single clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- In_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- In_valid  input  NCH  per-channel valid.
- In_ready  output  NCH  per-channel ready (combinational).
- Sel  input  SELW  channel index used in fixed mode.
- Mode  input  1  0 = fixed (Sel), 1 = round-robin.
- Out_data  output  WIDTH  registered data.
- Out_ch  output  SELW  registered index of the channel that produced Out_data.
- Out_valid  output  1  registered valid.
- Out_ready  input  1  consumer ready.

## Operation
- Transfer on any port occurs when valid && ready are both high at a rising Clk.
- load = ~Out_valid || Out_ready. The output register accepts a new beat only when load = 1.
- Grant selection (combinational, one channel at most):
  - Mode 0: grant = Sel if Sel < NCH and In_valid[Sel]; otherwise no grant. Sel >= NCH never grants.
  - Mode 1: grant = first i with In_valid[i], searching ptr+1, ptr+2, … with wrap modulo NCH; ptr itself is checked last. No valid channel means no grant.
- In_ready[i] = load && (grant == i). All non-granted channels see In_ready = 0.
- On a transfer: Out_data <= In_data[grant]; Out_ch <= grant; Out_valid <= 1; in Mode 1, ptr <= grant.
- When load = 1 and there is no grant: Out_valid <= 0. Out_data and Out_ch hold their values.
- When load = 0: all output registers hold. Out_data is stable while Out_valid && ~Out_ready.
- ptr updates only on Mode 1 transfers. It is retained across Mode 0 periods.
- Mode and Sel are sampled every cycle. A change affects the next grant only and never disturbs a held output beat.

## Timing
- Reset values (Rst high at a Clk edge): Out_valid = 0, Out_data = 0, Out_ch = 0, ptr = NCH-1, so channel 0 has first priority.
- Rst overrides everything, including a transfer in the same cycle. A held beat is discarded, and In_ready is 0 while Rst is high.
- Latency is 1 cycle: input accepted at edge k appears on Out_* after edge k.
- Throughput is one beat per cycle while Out_ready = 1 and a grant exists.
- Combinational paths are In_valid/Sel/Mode/Out_ready → In_ready. There is no path from In_* to Out_*.
- Simultaneous output drain and refill (Out_valid && Out_ready && grant) yields back-to-back beats with no bubble.
- Round-robin fairness: with all channels continuously valid and Out_ready = 1, grants cycle 0,1,…,NCH-1,0, and no channel waits more than NCH-1 grants.

## Structure
- Package stream_mux_pkg holds:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
  - A function returning the next index modulo NCH.
- Sub-module rr_arbiter (parameter NCH) is purely combinational.
  - Inputs: request vector and ptr.
  - Outputs: grant index and a grant_valid flag.
- The top level owns ptr, the output register, and the Mode 0/1 grant selection.

## Test plan
- Reset then idle: assert Rst for 2 cycles with all In_valid = 1 → Out_valid = 0, Out_data = 0, Out_ch = 0, In_ready = 0000 during reset.
- Fixed mode, WIDTH = 2, NCH = 4: channels carry data 3,2,1,0; Sel = 2, all valid, Out_ready = 1 → Out_data = 1, Out_ch = 2 one cycle later; In_ready = 0100 only.
- Round-robin, all valid, Out_ready = 1 for 8 cycles → Out_ch sequence 0,1,2,3,0,1,2,3 with no bubbles.
- Backpressure: Out_ready = 0 with Out_valid = 1 for 5 cycles → Out_data/Out_ch stable and In_ready = 0000. Then Out_ready = 1 → the next beat lands the following cycle, with no loss or duplication against a scoreboard.
- Sparse round-robin: only channels 1 and 3 valid, ptr = 1 → grant 3, then 1, then 3. Drop channel 3 valid → grant 1 continuously.
- Mode switch and reset mid-stream:
  - Switch Mode 1→0 with Sel = 0 while a beat is held → the held beat is unchanged; the next grant is channel 0.
  - Switching back to Mode 1 resumes from the retained ptr.
  - Rst pulsed while Out_valid = 1 → Out_valid = 0 the next cycle and ptr restarts at channel 0.
